tdc_encode_sequencer: RTL and testbench
=======================================

TDC_ENCODE_SEQUENCER -- requirements
Module: tdc_encode_sequencer

Interface
REQ-001 Parameter ENC_LATENCY, default 1, legal 1..3: cycles from driving the encoder inputs to a valid encoder result.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rstn  in  1  reset, asynchronous and active-low.
REQ-004 hit_valid  in  1  one-cycle pulse: the raw TOA/TOT/Cal codes below are valid.
REQ-005 toa_raw / tot_raw / cal_raw  in  63 each  thermometer-code delay-line samples.
REQ-006 toa_cnta, toa_cntb, tot_cnta, tot_cntb, cal_cnta, cal_cntb  in  3 each  ripple-counter A/B values per measurement.
REQ-007 toa_offset / tot_offset / cal_offset  in  7 each  per-measurement offset presented to the encoder.
REQ-008 cal_en  in  1  1 = encode the Cal slot; 0 = skip it.
REQ-009 enc_a  out  63, enc_countera  out  3, enc_counterb  out  3, enc_offset  out  7: shared encoder inputs.
REQ-010 enc_coarse  in  3, enc_fine  in  7, enc_err  in  1: shared encoder results.
REQ-011 out_valid  out  1, out_ready  in  1: result handshake.
REQ-012 toa_code / tot_code / cal_code  out  10 each  encoded results; err_flags  out  3 ({cal,tot,toa}).
REQ-013 busy  out  1: high whenever state is not IDLE.
REQ-014 drop_cnt  out  8, clr_drop  in  1: count of hits rejected while busy.

Function
REQ-015 States: IDLE, ENC_TOA, ENC_TOT, ENC_CAL, DONE.
REQ-016 IDLE with hit_valid=1 shall register all raw, counter, offset and cal_en inputs and enter ENC_TOA on that edge.
REQ-017 Each ENC_x state shall last exactly ENC_LATENCY cycles; on the last one it shall register {enc_coarse,enc_fine} into x_code and enc_err into the matching err_flags bit.
REQ-018 Transitions: ENC_TOA->ENC_TOT; ENC_TOT->ENC_CAL if latched cal_en=1, else DONE; ENC_CAL->DONE.
REQ-019 With cal_en=0, cal_code shall be 0 and err_flags[2] shall be 0 for that event.
REQ-020 In ENC_x, enc_* outputs shall carry the latched slot-x values; in IDLE and DONE they shall all be 0.
REQ-021 out_valid shall be 1 exactly in DONE; codes and err_flags shall be stable while out_valid=1.
REQ-022 DONE with out_ready=1 shall return to IDLE on that edge; out_ready is ignored outside DONE.
REQ-023 out_valid shall first rise 3*ENC_LATENCY cycles after the capture edge (2*ENC_LATENCY with cal_en=0).
REQ-024 hit_valid while busy=1, including the DONE cycle in which the handshake completes, shall be dropped and increment drop_cnt.
REQ-025 drop_cnt shall saturate at 255.
REQ-026 clr_drop=1 shall zero drop_cnt; clr_drop wins over a simultaneous drop.
REQ-027 Codes retain the last event's values in IDLE; a new capture does not clear them until overwritten per slot.

Reset
REQ-028 rstn=0 at any time, including mid-sequence, shall immediately force IDLE and zero all outputs: busy, out_valid, codes, err_flags, enc_* and drop_cnt.
REQ-029 The first hit after rstn deasserts shall be accepted normally; no partial event survives reset.

Verification
REQ-030 ENC_LATENCY=1, cal_en=1, hit with the encoder model returning TOA=(3,45), TOT=(1,10), Cal=(5,127) -> out_valid rises 3 cycles after capture; toa_code=429, tot_code=138, cal_code=767, err_flags=0.
REQ-031 cal_en=0, ENC_LATENCY=2 -> out_valid rises 4 cycles after capture; cal_code=0; ENC_CAL never entered.
REQ-032 out_ready held 0 for 10 cycles with 3 hits during DONE -> outputs stable; drop_cnt=3; the 4th hit after the handshake is accepted.
REQ-033 enc_err=1 only during the TOT slot -> err_flags=3'b010.
REQ-034 rstn pulsed low during ENC_TOT -> all outputs 0 asynchronously; the next hit yields a correct complete result.
REQ-035 300 hits while busy, then clr_drop asserted in the same cycle as a drop -> drop_cnt holds 255, then reads 0.

Source files
------------

// File: rtl/tdc_encode_sequencer_if.sv
// tdc_encode_sequencer_if: hit capture, shared-encoder and result handshake bundle.
interface tdc_encode_sequencer_if;
    logic        hit_valid;
    logic [62:0] toa_raw, tot_raw, cal_raw;
    logic [2:0]  toa_cnta, toa_cntb, tot_cnta, tot_cntb, cal_cnta, cal_cntb;
    logic [6:0]  toa_offset, tot_offset, cal_offset;
    logic        cal_en;
    logic [62:0] enc_a;
    logic [2:0]  enc_countera, enc_counterb;
    logic [6:0]  enc_offset;
    logic [2:0]  enc_coarse;
    logic [6:0]  enc_fine;
    logic        enc_err;
    logic        out_valid, out_ready;
    logic [9:0]  toa_code, tot_code, cal_code;
    logic [2:0]  err_flags;
    logic        busy;
    logic [7:0]  drop_cnt;
    logic        clr_drop;

    modport master (
        output hit_valid, toa_raw, tot_raw, cal_raw,
               toa_cnta, toa_cntb, tot_cnta, tot_cntb, cal_cnta, cal_cntb,
               toa_offset, tot_offset, cal_offset, cal_en,
               enc_coarse, enc_fine, enc_err, out_ready, clr_drop,
        input  enc_a, enc_countera, enc_counterb, enc_offset,
               out_valid, toa_code, tot_code, cal_code, err_flags, busy, drop_cnt
    );
    modport slave (
        input  hit_valid, toa_raw, tot_raw, cal_raw,
               toa_cnta, toa_cntb, tot_cnta, tot_cntb, cal_cnta, cal_cntb,
               toa_offset, tot_offset, cal_offset, cal_en,
               enc_coarse, enc_fine, enc_err, out_ready, clr_drop,
        output enc_a, enc_countera, enc_counterb, enc_offset,
               out_valid, toa_code, tot_code, cal_code, err_flags, busy, drop_cnt
    );
endinterface

// File: rtl/tdc_encode_sequencer.sv
// tdc_encode_sequencer: sequences one hit's TOA/TOT/Cal samples through a shared TDC encoder.
module tdc_encode_sequencer #(
    parameter int ENC_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    tdc_encode_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ENC_TOA, ENC_TOT, ENC_CAL, DONE} state_t;

    state_t      r_state, w_next;
    logic [1:0]  r_cnt;
    logic [62:0] r_toa_raw, r_tot_raw, r_cal_raw;
    logic [2:0]  r_toa_cnta, r_toa_cntb, r_tot_cnta, r_tot_cntb, r_cal_cnta, r_cal_cntb;
    logic [6:0]  r_toa_off, r_tot_off, r_cal_off;
    logic        r_cal_en;
    logic [9:0]  r_toa_code, r_tot_code, r_cal_code;
    logic [2:0]  r_err;
    logic [7:0]  r_drop;
    logic        w_last, w_cap, w_drop;
    logic [9:0]  w_res;

    assign w_last = r_cnt == 2'(ENC_LATENCY - 1);
    assign w_cap  = r_state == IDLE && bus.hit_valid;
    assign w_drop = r_state != IDLE && bus.hit_valid;
    assign w_res  = {bus.enc_coarse, bus.enc_fine};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_last || r_state == IDLE || r_state == DONE) ? '0 : r_cnt + 2'd1;
        end
    end

    always_comb begin
        w_next           = r_state;
        bus.enc_a        = '0;
        bus.enc_countera = '0;
        bus.enc_counterb = '0;
        bus.enc_offset   = '0;
        case (r_state)
            IDLE: w_next = bus.hit_valid ? ENC_TOA : IDLE;
            ENC_TOA: begin
                w_next           = w_last ? ENC_TOT : ENC_TOA;
                bus.enc_a        = r_toa_raw;
                bus.enc_countera = r_toa_cnta;
                bus.enc_counterb = r_toa_cntb;
                bus.enc_offset   = r_toa_off;
            end
            ENC_TOT: begin
                w_next           = !w_last ? ENC_TOT : r_cal_en ? ENC_CAL : DONE;
                bus.enc_a        = r_tot_raw;
                bus.enc_countera = r_tot_cnta;
                bus.enc_counterb = r_tot_cntb;
                bus.enc_offset   = r_tot_off;
            end
            ENC_CAL: begin
                w_next           = w_last ? DONE : ENC_CAL;
                bus.enc_a        = r_cal_raw;
                bus.enc_countera = r_cal_cnta;
                bus.enc_counterb = r_cal_cntb;
                bus.enc_offset   = r_cal_off;
            end
            DONE: w_next = bus.out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_toa_raw  <= '0;
            r_tot_raw  <= '0;
            r_cal_raw  <= '0;
            r_toa_cnta <= '0;
            r_toa_cntb <= '0;
            r_tot_cnta <= '0;
            r_tot_cntb <= '0;
            r_cal_cnta <= '0;
            r_cal_cntb <= '0;
            r_toa_off  <= '0;
            r_tot_off  <= '0;
            r_cal_off  <= '0;
            r_cal_en   <= 1'b0;
            r_toa_code <= '0;
            r_tot_code <= '0;
            r_cal_code <= '0;
            r_err      <= '0;
            r_drop     <= '0;
        end else begin
            if (w_cap) begin
                r_toa_raw  <= bus.toa_raw;
                r_tot_raw  <= bus.tot_raw;
                r_cal_raw  <= bus.cal_raw;
                r_toa_cnta <= bus.toa_cnta;
                r_toa_cntb <= bus.toa_cntb;
                r_tot_cnta <= bus.tot_cnta;
                r_tot_cntb <= bus.tot_cntb;
                r_cal_cnta <= bus.cal_cnta;
                r_cal_cntb <= bus.cal_cntb;
                r_toa_off  <= bus.toa_offset;
                r_tot_off  <= bus.tot_offset;
                r_cal_off  <= bus.cal_offset;
                r_cal_en   <= bus.cal_en;
                // a skipped Cal slot reports zero rather than the previous event's value
                if (!bus.cal_en) begin
                    r_cal_code <= '0;
                    r_err[2]   <= 1'b0;
                end
            end
            if (w_last && r_state == ENC_TOA) begin
                r_toa_code <= w_res;
                r_err[0]   <= bus.enc_err;
            end
            if (w_last && r_state == ENC_TOT) begin
                r_tot_code <= w_res;
                r_err[1]   <= bus.enc_err;
            end
            if (w_last && r_state == ENC_CAL) begin
                r_cal_code <= w_res;
                r_err[2]   <= bus.enc_err;
            end
            r_drop <= bus.clr_drop ? '0 : (w_drop && r_drop != 8'hFF) ? r_drop + 8'd1 : r_drop;
        end
    end

    assign bus.busy      = r_state != IDLE;
    assign bus.out_valid = r_state == DONE;
    assign bus.toa_code  = r_toa_code;
    assign bus.tot_code  = r_tot_code;
    assign bus.cal_code  = r_cal_code;
    assign bus.err_flags = r_err;
    assign bus.drop_cnt  = r_drop;
endmodule

// File: tb/tb_tdc_encode_sequencer.sv
// tb_tdc_encode_sequencer: scoreboard bench; instance A runs ENC_LATENCY=1, instance B ENC_LATENCY=2.
module tb_tdc_encode_sequencer;
    typedef struct {
        logic [62:0] ta, tt, tc;
        logic [2:0]  a0, b0, a1, b1, a2, b2;
        logic [6:0]  o0, o1, o2;
        logic        ce;
    } vec_t;
    typedef struct {
        logic [9:0] toa, tot, cal;
        logic [2:0] err;
        int         lat;
        int         cap;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t qa[$], qb[$];
    exp_t ca, cb;
    bit   pva = 0, pvb = 0, b_cal_seen = 0;

    logic [62:0] s_toa_raw = '0, s_tot_raw = '0, s_cal_raw = '0;
    logic [2:0]  s_a0 = '0, s_b0 = '0, s_a1 = '0, s_b1 = '0, s_a2 = '0, s_b2 = '0;
    logic [6:0]  s_o0 = '0, s_o1 = '0, s_o2 = '0;
    logic        s_ce = 1'b0;
    logic [2:0]  eb_c = '0;
    logic [6:0]  eb_f = '0;
    logic        eb_e = 1'b0;

    tdc_encode_sequencer_if ifa ();
    tdc_encode_sequencer_if ifb ();

    tdc_encode_sequencer #(.ENC_LATENCY(1)) u_a (.clk(clk), .rstn(rstn), .bus(ifa));
    tdc_encode_sequencer #(.ENC_LATENCY(2)) u_b (.clk(clk), .rstn(rstn), .bus(ifb));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign ifa.toa_raw = s_toa_raw;   assign ifb.toa_raw = s_toa_raw;
    assign ifa.tot_raw = s_tot_raw;   assign ifb.tot_raw = s_tot_raw;
    assign ifa.cal_raw = s_cal_raw;   assign ifb.cal_raw = s_cal_raw;
    assign ifa.toa_cnta = s_a0;       assign ifb.toa_cnta = s_a0;
    assign ifa.toa_cntb = s_b0;       assign ifb.toa_cntb = s_b0;
    assign ifa.tot_cnta = s_a1;       assign ifb.tot_cnta = s_a1;
    assign ifa.tot_cntb = s_b1;       assign ifb.tot_cntb = s_b1;
    assign ifa.cal_cnta = s_a2;       assign ifb.cal_cnta = s_a2;
    assign ifa.cal_cntb = s_b2;       assign ifb.cal_cntb = s_b2;
    assign ifa.toa_offset = s_o0;     assign ifb.toa_offset = s_o0;
    assign ifa.tot_offset = s_o1;     assign ifb.tot_offset = s_o1;
    assign ifa.cal_offset = s_o2;     assign ifb.cal_offset = s_o2;
    assign ifa.cal_en = s_ce;         assign ifb.cal_en = s_ce;

    // encoder model: coarse = cntA^cntB, fine = ones-count + offset, err = top delay-line tap set
    assign ifa.enc_coarse = ifa.enc_countera ^ ifa.enc_counterb;
    assign ifa.enc_fine   = 7'($countones(ifa.enc_a)) + ifa.enc_offset;
    assign ifa.enc_err    = ifa.enc_a[62];
    always @(posedge clk) begin
        eb_c <= ifb.enc_countera ^ ifb.enc_counterb;
        eb_f <= 7'($countones(ifb.enc_a)) + ifb.enc_offset;
        eb_e <= ifb.enc_a[62];
    end
    assign ifb.enc_coarse = eb_c;
    assign ifb.enc_fine   = eb_f;
    assign ifb.enc_err    = eb_e;

    function automatic logic [62:0] therm(input int n);
        return (63'd1 << n) - 63'd1;
    endfunction

    function automatic vec_t mkv(input int n0, n1, n2, input logic [2:0] a0, b0, a1, b1, a2, b2,
                                 input logic [6:0] o0, o1, o2, input logic ce);
        vec_t v;
        v.ta = therm(n0); v.tt = therm(n1); v.tc = therm(n2);
        v.a0 = a0; v.b0 = b0; v.a1 = a1; v.b1 = b1; v.a2 = a2; v.b2 = b2;
        v.o0 = o0; v.o1 = o1; v.o2 = o2; v.ce = ce;
        return v;
    endfunction

    function automatic exp_t mke(input int t, tt, c, input logic [2:0] e, input int lat);
        exp_t x;
        x.toa = 10'(t); x.tot = 10'(tt); x.cal = 10'(c); x.err = e; x.lat = lat; x.cap = 0;
        return x;
    endfunction

    task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", n, act, req, cyc);
        end
    endtask

    task automatic set_vec(input vec_t v);
        s_toa_raw = v.ta; s_tot_raw = v.tt; s_cal_raw = v.tc;
        s_a0 = v.a0; s_b0 = v.b0; s_a1 = v.a1; s_b1 = v.b1; s_a2 = v.a2; s_b2 = v.b2;
        s_o0 = v.o0; s_o1 = v.o1; s_o2 = v.o2; s_ce = v.ce;
    endtask

    task automatic issue(input bit b, input vec_t v, input exp_t e);
        set_vec(v);
        if (b) ifb.hit_valid = 1'b1; else ifa.hit_valid = 1'b1;
        @(posedge clk); #1;
        ifa.hit_valid = 1'b0;
        ifb.hit_valid = 1'b0;
        e.cap = cyc;
        if (b) qb.push_back(e); else qa.push_back(e);
    endtask

    task automatic drain(input bit b);
        for (int i = 0; i < 200; i++) begin
            if (b ? (qb.size() == 0 && !ifb.busy) : (qa.size() == 0 && !ifa.busy)) break;
            @(negedge clk);
        end
        cmp(b ? "b_drain" : "a_drain", b ? 32'(qb.size()) + 32'(ifb.busy) : 32'(qa.size()) + 32'(ifa.busy), 0);
    endtask

    task automatic wait_valid_a();
        for (int i = 0; i < 50; i++) begin
            if (ifa.out_valid) break;
            @(negedge clk);
        end
        cmp("a_wait_valid", 32'(ifa.out_valid), 1);
    endtask

    always @(negedge clk) begin
        if (ifa.out_valid) begin
            if (!pva) begin
                if (qa.size() == 0) cmp("a_unexpected_result", 0, 1);
                else begin
                    ca = qa.pop_front();
                    cmp("a_latency", 32'(cyc - ca.cap), 32'(ca.lat));
                end
            end
            cmp("a_toa_code", 32'(ifa.toa_code), 32'(ca.toa));
            cmp("a_tot_code", 32'(ifa.tot_code), 32'(ca.tot));
            cmp("a_cal_code", 32'(ifa.cal_code), 32'(ca.cal));
            cmp("a_err_flags", 32'(ifa.err_flags), 32'(ca.err));
        end
        pva = ifa.out_valid;
    end

    always @(negedge clk) begin
        if (ifb.busy && ifb.enc_a == {63{1'b1}}) b_cal_seen = 1;
        if (ifb.out_valid) begin
            if (!pvb) begin
                if (qb.size() == 0) cmp("b_unexpected_result", 0, 1);
                else begin
                    cb = qb.pop_front();
                    cmp("b_latency", 32'(cyc - cb.cap), 32'(cb.lat));
                end
            end
            cmp("b_toa_code", 32'(ifb.toa_code), 32'(cb.toa));
            cmp("b_tot_code", 32'(ifb.tot_code), 32'(cb.tot));
            cmp("b_cal_code", 32'(ifb.cal_code), 32'(cb.cal));
            cmp("b_err_flags", 32'(ifb.err_flags), 32'(cb.err));
        end
        pvb = ifb.out_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v1, v2, v3, vb;
        exp_t e1, e2, e3, eb;
        v1 = mkv(40, 10, 62, 3, 0, 1, 0, 5, 0, 5, 0, 65, 1);
        e1 = mke(429, 138, 767, 3'b000, 3);
        v2 = mkv(1, 63, 20, 7, 1, 2, 1, 4, 4, 2, 0, 0, 1);
        e2 = mke(771, 447, 20, 3'b010, 3);
        v3 = mkv(63, 7, 63, 1, 0, 6, 3, 7, 0, 64, 7, 9, 0);
        e3 = mke(255, 654, 0, 3'b001, 2);
        vb = mkv(30, 5, 63, 2, 0, 1, 1, 7, 0, 1, 3, 9, 0);
        eb = mke(287, 8, 0, 3'b000, 4);
        ifa.hit_valid = 0; ifa.out_ready = 1; ifa.clr_drop = 0;
        ifb.hit_valid = 0; ifb.out_ready = 1; ifb.clr_drop = 0;
        #12;
        cmp("rst_busy", 32'(ifa.busy), 0);
        cmp("rst_out_valid", 32'(ifa.out_valid), 0);
        cmp("rst_toa_code", 32'(ifa.toa_code), 0);
        cmp("rst_err_flags", 32'(ifa.err_flags), 0);
        cmp("rst_enc_a_zero", 32'(ifa.enc_a != 0), 0);
        cmp("rst_drop_cnt", 32'(ifa.drop_cnt), 0);
        @(negedge clk); rstn = 1;
        @(negedge clk);
        issue(1, vb, eb);
        drain(1);
        cmp("b_cal_slot_never_entered", 32'(b_cal_seen), 0);
        @(negedge clk);
        issue(0, v1, e1);
        drain(0);
        cmp("a_idle_retains_toa", 32'(ifa.toa_code), 429);
        issue(0, v2, e2);
        drain(0);
        issue(0, v3, e3);
        drain(0);
        ifa.out_ready = 0;
        issue(0, v1, e1);
        wait_valid_a();
        cmp("a_done_enc_a_zero", 32'(ifa.enc_a != 0), 0);
        cmp("a_done_enc_offset", 32'(ifa.enc_offset), 0);
        for (int i = 0; i < 10; i++) begin
            ifa.hit_valid = (i == 2 || i == 5 || i == 8);
            @(negedge clk);
        end
        ifa.hit_valid = 0;
        cmp("a_stall_out_valid", 32'(ifa.out_valid), 1);
        cmp("a_stall_drop_cnt", 32'(ifa.drop_cnt), 3);
        ifa.out_ready = 1;
        @(negedge clk);
        cmp("a_after_handshake_busy", 32'(ifa.busy), 0);
        issue(0, v2, e2);
        drain(0);
        ifa.out_ready = 0;
        issue(0, v3, e3);
        wait_valid_a();
        ifa.out_ready = 1;
        ifa.hit_valid = 1;
        @(negedge clk);
        ifa.hit_valid = 0;
        cmp("a_handshake_drop_cnt", 32'(ifa.drop_cnt), 4);
        cmp("a_handshake_hit_not_captured", 32'(ifa.busy), 0);
        @(negedge clk);
        set_vec(v1);
        ifa.hit_valid = 1;
        @(posedge clk); #1;
        ifa.hit_valid = 0;
        @(posedge clk); #2;
        rstn = 0;
        #1;
        cmp("arst_busy", 32'(ifa.busy), 0);
        cmp("arst_out_valid", 32'(ifa.out_valid), 0);
        cmp("arst_toa_code", 32'(ifa.toa_code), 0);
        cmp("arst_tot_code", 32'(ifa.tot_code), 0);
        cmp("arst_cal_code", 32'(ifa.cal_code), 0);
        cmp("arst_err_flags", 32'(ifa.err_flags), 0);
        cmp("arst_enc_a_zero", 32'(ifa.enc_a != 0), 0);
        cmp("arst_enc_counters", 32'({ifa.enc_countera, ifa.enc_counterb}), 0);
        cmp("arst_drop_cnt", 32'(ifa.drop_cnt), 0);
        @(negedge clk); rstn = 1;
        @(negedge clk);
        issue(0, v2, e2);
        drain(0);
        ifa.out_ready = 0;
        issue(0, v1, e1);
        ifa.hit_valid = 1;
        repeat (300) @(posedge clk);
        #1;
        ifa.hit_valid = 0;
        cmp("a_drop_saturated", 32'(ifa.drop_cnt), 255);
        @(negedge clk);
        ifa.hit_valid = 1;
        @(negedge clk);
        cmp("a_drop_holds_255", 32'(ifa.drop_cnt), 255);
        ifa.clr_drop = 1;
        @(negedge clk);
        ifa.clr_drop = 0;
        ifa.hit_valid = 0;
        cmp("a_clr_beats_drop", 32'(ifa.drop_cnt), 0);
        ifa.out_ready = 1;
        drain(0);
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
